rf_snapshot_ctrl: RTL

RF_SNAPSHOT_CTRL -- requirements
Module: rf_snapshot_ctrl

---
 rtl/rf_snapshot_ctrl_pkg.sv | 16 +
 rtl/rf_snapshot_ctrl_if.sv | 22 ++
 rtl/rf_snapshot_ctrl_sat_counter.sv | 20 ++
 rtl/rf_snapshot_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rf_snapshot_ctrl_pkg.sv
// Shared types and constants for the register-file snapshot controller.
package rf_snap_pkg;

  localparam int NREG  = 32;
  localparam int XLEN  = 32;
  localparam int IDX_W = $clog2(NREG);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rf_snapshot_ctrl_if.sv
// Snapshot beat stream: controller (master) to trace sink (slave).
interface rf_snapshot_ctrl_if;
  import rf_snap_pkg::*;

  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] idx;
  logic [XLEN-1:0]  data;
  logic [XLEN-1:0]  pc;
  logic             last;

  modport master (
    output valid, idx, data, pc, last,
    input  ready
  );

  modport slave (
    input  valid, idx, data, pc, last,
    output ready
  );

endinterface

// File: rtl/rf_snapshot_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Count increments, sticking at the maximum value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rf_snapshot_ctrl.sv
// Register-file snapshot controller: on each accepted commit, walks the
// register file through the shared read port and streams one beat per
// register; debug reads borrow the port whenever the scan does not need it.
module rf_snapshot_ctrl
  import rf_snap_pkg::*;
#(
  parameter int SKIP_X0 = 1,
  parameter int DROP_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                commit_valid,
  input  logic [XLEN-1:0]     commit_pc,
  output logic [IDX_W-1:0]    rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  input  logic                dbg_req,
  input  logic [IDX_W-1:0]    dbg_addr,
  output logic                dbg_gnt,
  output logic [XLEN-1:0]     dbg_rdata,
  rf_snapshot_ctrl_if.master  snap,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam logic [IDX_W-1:0] START_IDX = (SKIP_X0 != 0) ? IDX_W'(1) : IDX_W'(0);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             snap_valid_q;
  logic [IDX_W-1:0] snap_idx_q;
  logic [XLEN-1:0]  snap_data_q;
  logic [XLEN-1:0]  snap_pc_q;
  logic             snap_last_q;

  logic scan_fire;
  logic accept;
  logic drop;

  // Gating with reset keeps the port idle while reset is held, even though
  // the state register only clears on the next edge.
  assign scan_fire = reset && (state == SCAN) && (!snap_valid_q || snap.ready);
  assign accept    = snap_valid_q && snap.ready;
  assign dbg_gnt   = reset && dbg_req && !scan_fire;
  assign busy      = (state != IDLE);
  assign drop      = reset && commit_valid && (state != IDLE);

  assign snap.valid = snap_valid_q;
  assign snap.idx   = snap_idx_q;
  assign snap.data  = snap_data_q;
  assign snap.pc    = snap_pc_q;
  assign snap.last  = snap_last_q;

  // Shared read-port mux: scan first, then debug, otherwise parked at x0.
  always_comb begin
    rf_raddr  = '0;
    dbg_rdata = '0;
    if (scan_fire) begin
      rf_raddr = idx;
    end else if (dbg_gnt) begin
      rf_raddr  = dbg_addr;
      dbg_rdata = rf_rdata;
    end
  end

  // Scan sequencing plus the beat output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      snap_valid_q <= 1'b0;
      snap_idx_q   <= '0;
      snap_data_q  <= '0;
      snap_pc_q    <= '0;
      snap_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (commit_valid) begin
            snap_pc_q <= commit_pc;
            idx       <= START_IDX;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (scan_fire) begin
            if (idx == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Only the final beat can still be pending here.
          if (accept) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (scan_fire) begin
        snap_valid_q <= 1'b1;
        snap_idx_q   <= idx;
        snap_data_q  <= rf_rdata;
        snap_last_q  <= (idx == LAST_IDX);
      end else if (accept) begin
        snap_valid_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .width(DROP_W)
  ) u_drop (
    .clock (clock),
    .reset (reset),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule
